// File: rtl/uart_pkg.sv
// Shared types and constants for the 8N1 UART transmitter slice.
package uart_pkg;

   typedef enum logic [1:0] {
      IDLE,
      START,
      DATA,
      STOP
   } tx_state_t;

   localparam int unsigned OVERSAMPLE   = 16;
   localparam int unsigned DATA_BITS    = 8;
   localparam int unsigned BAUD_W       = 17;
   localparam int unsigned DEF_CLK_FREQ = 100_000_000;
   localparam int unsigned DEF_ACC_W    = 28;

endpackage

// File: rtl/uart_tx_core_if.sv
// Host-side request/data/baud bundle plus the serial line of the transmitter.
interface uart_tx_core_if import uart_pkg::*; ();

   logic [BAUD_W-1:0]    Baud_Rate;
   logic                 UART_STA_TX;
   logic [DATA_BITS-1:0] UART_TxREG;
   logic                 UART_TXD;

   modport master (
      output Baud_Rate,
      output UART_STA_TX,
      output UART_TxREG,
      input  UART_TXD
   );

   modport slave (
      input  Baud_Rate,
      input  UART_STA_TX,
      input  UART_TxREG,
      output UART_TXD
   );

endinterface

// File: rtl/uart_baud_gen.sv
// NCO baud tick generator: one-cycle ticks at OVERSAMPLE*baud per second with
// no divider, so the error never accumulates across the bits of a frame.
module uart_baud_gen import uart_pkg::*; #(
   parameter int unsigned CLK_FREQ = DEF_CLK_FREQ,
   parameter int unsigned ACC_W    = DEF_ACC_W
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              clear,
   input  logic [BAUD_W-1:0] baud,
   output logic              tick
);

   localparam logic [ACC_W:0] FREQ = (ACC_W+1)'(CLK_FREQ);

   logic [ACC_W-1:0] acc;
   logic [ACC_W-1:0] acc_nxt;
   logic [ACC_W:0]   inc;
   logic [ACC_W:0]   sum;

   always_comb begin
      inc = (ACC_W+1)'(baud) * (ACC_W+1)'(OVERSAMPLE);
      // Clamping to CLK_FREQ saturates at one tick per clock and keeps acc < CLK_FREQ.
      if (inc > FREQ) begin
         inc = FREQ;
      end
      sum     = {1'b0, acc} + inc;
      tick    = (sum >= FREQ);
      acc_nxt = tick ? ACC_W'(sum - FREQ) : ACC_W'(sum);
   end

   // NOTE: flops are written with non-blocking (<=) so every register samples pre-edge values.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         acc <= '0;
      end else if (clear) begin
         acc <= '0;
      end else begin
         acc <= acc_nxt;
      end
   end

endmodule

// File: rtl/uart_tx_core.sv
// Transmit-only 8N1 UART: latches a byte and baud at frame start and shifts
// start, 8 data bits LSB first and stop onto a registered, glitch-free TXD.
module uart_tx_core import uart_pkg::*; #(
   parameter int unsigned CLK_FREQ = DEF_CLK_FREQ,
   parameter int unsigned ACC_W    = DEF_ACC_W
) (
   input logic           clk,
   input logic           rst,
   uart_tx_core_if.slave tx
);

   localparam logic [3:0] LAST_TICK = 4'(OVERSAMPLE - 1);
   localparam logic [2:0] LAST_BIT  = 3'(DATA_BITS - 1);

   tx_state_t            state, state_nxt;
   logic [DATA_BITS-1:0] shift_q, shift_nxt;
   logic [BAUD_W-1:0]    baud_q, baud_nxt;
   logic [3:0]           tick_cnt, tick_cnt_nxt;
   logic [2:0]           bit_idx, bit_idx_nxt;
   logic                 txd_q, txd_nxt;
   logic                 tick;
   logic                 acc_clear;
   logic                 bit_end;

   uart_baud_gen #(
      .CLK_FREQ (CLK_FREQ),
      .ACC_W    (ACC_W)
   ) u_baud_gen (
      .clk   (clk),
      .rst   (rst),
      .clear (acc_clear),
      .baud  (baud_q),
      .tick  (tick)
   );

   assign bit_end = tick && (tick_cnt == LAST_TICK);

   // NOTE: every signal gets a default before the case so no path leaves it unassigned (no latch).
   always_comb begin
      state_nxt    = state;
      shift_nxt    = shift_q;
      baud_nxt     = baud_q;
      tick_cnt_nxt = tick ? tick_cnt + 4'd1 : tick_cnt;
      bit_idx_nxt  = bit_idx;
      acc_clear    = 1'b0;
      txd_nxt      = 1'b1;

      unique case (state)
         IDLE: begin
            tick_cnt_nxt = '0;
            if (tx.UART_STA_TX && (tx.Baud_Rate != '0)) begin
               state_nxt   = START;
               shift_nxt   = tx.UART_TxREG;
               baud_nxt    = tx.Baud_Rate;
               bit_idx_nxt = '0;
               acc_clear   = 1'b1;
            end
         end
         START: begin
            if (bit_end) begin
               state_nxt   = DATA;
               bit_idx_nxt = '0;
            end
         end
         DATA: begin
            if (bit_end) begin
               shift_nxt = shift_q >> 1;
               if (bit_idx == LAST_BIT) begin
                  state_nxt = STOP;
               end else begin
                  bit_idx_nxt = bit_idx + 3'd1;
               end
            end
         end
         STOP: begin
            if (bit_end) begin
               state_nxt = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase

      // TXD is registered from the next state so the line changes exactly on the edge.
      unique case (state_nxt)
         START:   txd_nxt = 1'b0;
         DATA:    txd_nxt = shift_nxt[0];
         default: txd_nxt = 1'b1;
      endcase
   end

   // rst is released synchronously to clk upstream; its assertion forces TXD high at once.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state    <= IDLE;
         shift_q  <= '0;
         baud_q   <= '0;
         tick_cnt <= '0;
         bit_idx  <= '0;
         txd_q    <= 1'b1;
      end else begin
         state    <= state_nxt;
         shift_q  <= shift_nxt;
         baud_q   <= baud_nxt;
         tick_cnt <= tick_cnt_nxt;
         bit_idx  <= bit_idx_nxt;
         txd_q    <= txd_nxt;
      end
   end

   assign tx.UART_TXD = txd_q;

endmodule

// File: tb/tb_uart_tx_core.sv
// Self-checking bench for uart_tx_core: table-driven frames checked through a
// scoreboard queue, plus hand-written reset, back-to-back and mid-frame sequences.
`timescale 1ns/1ps
module tb_uart_tx_core;

   localparam int unsigned TB_CLK_FREQ = 2_000_000;
   localparam int unsigned START_WAIT  = 64;

   typedef struct {
      logic [7:0]  data;
      int unsigned baud;
      logic [9:0]  bits;   // serial order: bit 0 = start, bit 9 = stop
   } vec_t;

   typedef struct {
      logic [9:0]  bits;
      int unsigned baud;
   } exp_t;

   logic clk = 1'b0;
   logic rst;

   uart_tx_core_if u_if ();

   uart_tx_core #(
      .CLK_FREQ (TB_CLK_FREQ),
      .ACC_W    (28)
   ) dut (
      .clk (clk),
      .rst (rst),
      .tx  (u_if)
   );

   always #5 clk = ~clk;

   int     n_checks = 0;
   int     n_fail   = 0;
   exp_t   sb_q[$];
   longint cyc        = 0;
   longint last_start = 0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input longint actual, input longint expected);
      n_checks++;
      if (actual != expected) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", name, actual, expected);
      end
   endtask

   task automatic check_range(input string name, input longint actual, input longint lo,
                              input longint hi);
      n_checks++;
      if (actual < lo || actual > hi) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d..%0d", name, actual, lo, hi);
      end
   endtask

   task automatic push_frame(input logic [9:0] bits, input int unsigned baud);
      exp_t e;
      e.bits = bits;
      e.baud = baud;
      sb_q.push_back(e);
   endtask

   task automatic wait_start(output bit ok);
      int unsigned waited = 0;
      while (u_if.UART_TXD !== 1'b0 && waited < START_WAIT) begin
         @(negedge clk);
         waited++;
      end
      ok = (u_if.UART_TXD === 1'b0);
   endtask

   task automatic check_idle(input string name, input int unsigned cycles);
      int bad = 0;
      repeat (cycles) begin
         if (u_if.UART_TXD !== 1'b1) bad++;
         @(negedge clk);
      end
      check(name, bad, 0);
   endtask

   // Pops one expected frame and compares TXD on every cycle more than one clock
   // away from an ideal bit boundary k*CLK/baud measured from the falling edge.
   task automatic check_frame(input string name, input bit drop_sta, input bit chk_period);
      exp_t   e;
      bit     ok;
      longint t0, nframe, pos, rem, ideal10;
      int     idx;
      int     bad[10];
      if (sb_q.size() == 0) begin
         check({name, " scoreboard depth"}, 0, 1);
         return;
      end
      e = sb_q.pop_front();
      wait_start(ok);
      check({name, " start seen"}, longint'(ok), 1);
      if (!ok) return;
      t0 = cyc;
      if (drop_sta) u_if.UART_STA_TX = 1'b0;
      ideal10 = 10 * longint'(TB_CLK_FREQ);
      if (chk_period) begin
         check_range({name, " period"}, t0 - last_start, (ideal10 + e.baud - 1) / e.baud,
                     ideal10 / e.baud + 2);
      end
      last_start = t0;
      for (int i = 0; i < 10; i++) bad[i] = 0;
      nframe = (ideal10 + e.baud - 1) / e.baud;
      for (longint n = 0; n < nframe; n++) begin
         pos = n * e.baud;
         idx = int'(pos / TB_CLK_FREQ);
         rem = pos % TB_CLK_FREQ;
         if (rem >= e.baud && (TB_CLK_FREQ - rem) >= e.baud && idx < 10) begin
            if (u_if.UART_TXD !== e.bits[idx]) bad[idx]++;
         end
         @(negedge clk);
      end
      for (int i = 0; i < 10; i++) begin
         check($sformatf("%s bit%0d bad cycles", name, i), bad[i], 0);
      end
   endtask

   task automatic disturb_mid_frame();
      bit ok;
      wait_start(ok);
      // 933 clocks after the falling edge at 9600 baud lands inside data bit 3.
      repeat (933) @(negedge clk);
      u_if.UART_TxREG   = 8'h00;
      u_if.Baud_Rate    = 17'd1200;
      u_if.UART_STA_TX  = 1'b0;
   endtask

   initial begin
      #(900_000_000);
      $display("FAIL watchdog: simulation exceeded its time budget");
      $fatal(1, "watchdog");
   end

   initial begin
      vec_t vecs[6];
      int   bad;
      bit   ok;

      vecs[0] = '{8'hAA, 1200,   10'b11_0101_0100};
      vecs[1] = '{8'h55, 115200, 10'b10_1010_1010};
      vecs[2] = '{8'h00, 57600,  10'b10_0000_0000};
      vecs[3] = '{8'hFF, 19200,  10'b11_1111_1110};
      vecs[4] = '{8'h01, 9600,   10'b10_0000_0010};
      vecs[5] = '{8'h80, 38400,  10'b11_0000_0000};

      // Reset held with a request pending: TXD must stay at mark level.
      rst              = 1'b0;
      u_if.UART_STA_TX = 1'b1;
      u_if.Baud_Rate   = 17'd115200;
      u_if.UART_TxREG  = 8'h55;
      bad = 0;
      repeat (5) begin
         @(negedge clk);
         if (u_if.UART_TXD !== 1'b1) bad++;
      end
      check("reset txd high", bad, 0);

      // Release with request held: start bit one clock later, then back-to-back frames.
      rst = 1'b1;
      for (int i = 0; i < 3; i++) push_frame(10'b10_1010_1010, 115200);
      @(negedge clk);
      check("release latency txd", longint'(u_if.UART_TXD === 1'b0), 1);
      check_frame("b2b0", 1'b0, 1'b0);
      check_frame("b2b1", 1'b0, 1'b1);
      check_frame("b2b2", 1'b1, 1'b1);
      check_idle("b2b idle", 200);

      for (int i = 0; i < 6; i++) begin
         u_if.UART_TxREG  = vecs[i].data;
         u_if.Baud_Rate   = 17'(vecs[i].baud);
         u_if.UART_STA_TX = 1'b1;
         push_frame(vecs[i].bits, vecs[i].baud);
         check_frame($sformatf("vec%0d", i), 1'b1, 1'b0);
         check_idle($sformatf("vec%0d idle", i), 50);
      end

      // No request, then request with baud disabled: line stays at mark.
      u_if.UART_STA_TX = 1'b0;
      u_if.Baud_Rate   = 17'd9600;
      check_idle("sta low idle", 5000);
      u_if.Baud_Rate   = 17'd0;
      u_if.UART_STA_TX = 1'b1;
      check_idle("baud zero idle", 2000);
      u_if.UART_STA_TX = 1'b0;
      @(negedge clk);

      // Data, baud and request all change during data bit 3; frame must be unaffected.
      u_if.UART_TxREG  = 8'hC3;
      u_if.Baud_Rate   = 17'd9600;
      u_if.UART_STA_TX = 1'b1;
      push_frame(10'b11_1000_0110, 9600);
      fork
         check_frame("midchg", 1'b0, 1'b0);
         disturb_mid_frame();
      join
      check_idle("midchg idle", 300);

      // Reset during data bit 4, then a fresh frame after release.
      u_if.UART_TxREG  = 8'h0F;
      u_if.Baud_Rate   = 17'd9600;
      u_if.UART_STA_TX = 1'b1;
      wait_start(ok);
      check("abort frame start seen", longint'(ok), 1);
      repeat (1140) @(negedge clk);
      check("pre-reset data bit 4 low", longint'(u_if.UART_TXD === 1'b0), 1);
      @(posedge clk);
      #2 rst = 1'b0;
      #1 check("async reset txd", longint'(u_if.UART_TXD === 1'b1), 1);
      u_if.UART_TxREG = 8'hA5;
      bad = 0;
      repeat (3) begin
         @(negedge clk);
         if (u_if.UART_TXD !== 1'b1) bad++;
      end
      check("mid-frame reset hold", bad, 0);
      rst = 1'b1;
      push_frame(10'b11_0100_1010, 9600);
      @(negedge clk);
      check("post-reset latency txd", longint'(u_if.UART_TXD === 1'b0), 1);
      check_frame("fresh", 1'b1, 1'b0);
      check_idle("fresh idle", 300);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
